elevator_dispatcher: RTL and testbench

Hall-call scheduler in front of the single-car elevator controller. Latches one pending call per floor (origin floor plus requested destination), then issues those calls to the car one at a time using round-robin arbitration. It drives the car's enable, origin and destination inputs and tracks the car's idle output for acceptance and completion. Emergency stop freezes dispatch without losing queued calls.

---
 rtl/elevator_dispatcher.sv | 236 +++++++++++++++++++++++
 tb/tb_elevator_dispatcher.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_dispatcher.sv
// -----------------------------------------------------------------------------
// elevator_dispatcher
// Hall-call scheduler for a single-car elevator. Each floor may hold one
// pending call (origin = floor index, plus a stored destination). Pending
// calls are issued to the car one at a time in round-robin order. The car's
// idle flag marks acceptance (idle drops) and completion (idle returns).
// Emergency stop freezes dispatch but keeps every queued call.
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous active-low reset, clears all state
//   call_req       per-floor call request, held until ack or reject
//   call_dest      per-floor destination, slice [f*FW +: FW]
//   emergency_stop active-high dispatch halt
//   car_idle       car controller idle flag
//   car_en         request-valid to the car
//   car_origin     origin floor of the issued call
//   car_dest       destination of the issued call
//   call_ack       one-cycle pulse, call latched
//   call_reject    one-cycle pulse, call invalid and dropped
//   call_pending   pending bit per floor
//   busy           high whenever the dispatcher is not idle
// -----------------------------------------------------------------------------
module elevator_dispatcher #(
    parameter int NFLOORS        = 5,
    parameter int FW             = 3,
    parameter int ACCEPT_TIMEOUT = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NFLOORS-1:0]    call_req,
    input  logic [NFLOORS*FW-1:0] call_dest,
    input  logic                  emergency_stop,
    input  logic                  car_idle,
    output logic                  car_en,
    output logic [FW-1:0]         car_origin,
    output logic [FW-1:0]         car_dest,
    output logic [NFLOORS-1:0]    call_ack,
    output logic [NFLOORS-1:0]    call_reject,
    output logic [NFLOORS-1:0]    call_pending,
    output logic                  busy
);

    localparam int              CW        = $clog2(ACCEPT_TIMEOUT + 1);
    localparam logic [CW-1:0]   CNT_LAST  = CW'(ACCEPT_TIMEOUT - 1);
    localparam logic [FW:0]     FLOOR_LIM = (FW+1)'(NFLOORS);
    localparam logic [FW-1:0]   FLOOR_TOP = FW'(NFLOORS - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DISPATCH  = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_HALT      = 2'd3
    } state_t;

    state_t              state_r, state_s;
    logic [NFLOORS-1:0]  pending_r, pending_s;
    logic [NFLOORS-1:0]  set_s, reject_s, clr_s;
    logic [FW-1:0]       dest_r [NFLOORS];
    logic [FW-1:0]       ptr_r, ptr_s;
    logic [CW-1:0]       cnt_r, cnt_s;
    logic                car_en_r, car_en_s;
    logic [FW-1:0]       origin_r, origin_s;
    logic [FW-1:0]       cdest_r, cdest_s;
    logic [NFLOORS-1:0]  ack_r, reject_r;
    logic                busy_r, busy_s;
    logic                sel_valid_s;
    logic [FW-1:0]       sel_floor_s;

    // Successor floor with wrap from the top floor back to floor 0.
    function automatic logic [FW-1:0] next_floor(input logic [FW-1:0] f);
        logic [FW-1:0] n;
        if (f == FLOOR_TOP) begin
            n = '0;
        end else begin
            n = f + 1'b1;
        end
        return n;
    endfunction

    // Round-robin search: first pending floor at or after ptr, wrapping.
    always_comb begin
        logic [FW-1:0] idx_v;
        sel_valid_s = 1'b0;
        sel_floor_s = '0;
        idx_v       = ptr_r;
        for (int i = 0; i < NFLOORS; i++) begin
            if (!sel_valid_s && pending_r[idx_v]) begin
                sel_valid_s = 1'b1;
                sel_floor_s = idx_v;
            end else begin
                sel_valid_s = sel_valid_s;
            end
            idx_v = next_floor(idx_v);
        end
    end

    // Validate new calls; a floor that already has a pending call ignores its request.
    always_comb begin
        set_s    = '0;
        reject_s = '0;
        for (int f = 0; f < NFLOORS; f++) begin
            if (call_req[f] && !pending_r[f]) begin
                if ((call_dest[f*FW +: FW] == FW'(f)) ||
                    ({1'b0, call_dest[f*FW +: FW]} >= FLOOR_LIM)) begin
                    reject_s[f] = 1'b1;
                end else begin
                    set_s[f] = 1'b1;
                end
            end else begin
                set_s[f] = 1'b0;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; emergency stop overrides every other transition.
    always_comb begin
        state_s = state_r;
        if (emergency_stop) begin
            state_s = ST_HALT;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (sel_valid_s && car_idle) state_s = ST_DISPATCH;
                    else                         state_s = ST_IDLE;
                end
                ST_DISPATCH: begin
                    if (!car_idle)                state_s = ST_WAIT_DONE;
                    else if (cnt_r == CNT_LAST)   state_s = ST_IDLE;
                    else                          state_s = ST_DISPATCH;
                end
                ST_WAIT_DONE: begin
                    if (car_idle) state_s = ST_IDLE;
                    else          state_s = ST_WAIT_DONE;
                end
                ST_HALT: begin
                    if (car_idle) state_s = ST_IDLE;
                    else          state_s = ST_HALT;
                end
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // Next values of the registered outputs, pointer, counter and pending store.
    always_comb begin
        car_en_s = car_en_r;
        origin_s = origin_r;
        cdest_s  = cdest_r;
        ptr_s    = ptr_r;
        cnt_s    = cnt_r;
        clr_s    = '0;
        if (emergency_stop) begin
            car_en_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (sel_valid_s && car_idle) begin
                        car_en_s = 1'b1;
                        origin_s = sel_floor_s;
                        cdest_s  = dest_r[sel_floor_s];
                        cnt_s    = '0;
                    end else begin
                        car_en_s = 1'b0;
                    end
                end
                ST_DISPATCH: begin
                    if (!car_idle) begin
                        car_en_s = 1'b0;
                        clr_s    = {{(NFLOORS-1){1'b0}}, 1'b1} << origin_r;
                        ptr_s    = next_floor(origin_r);
                    end else if (cnt_r == CNT_LAST) begin
                        // Unaccepted call stays pending; moving ptr on avoids starving others.
                        car_en_s = 1'b0;
                        ptr_s    = next_floor(origin_r);
                    end else begin
                        cnt_s = cnt_r + 1'b1;
                    end
                end
                ST_WAIT_DONE: car_en_s = 1'b0;
                ST_HALT:      car_en_s = 1'b0;
                default:      car_en_s = 1'b0;
            endcase
        end
        // Set and clear never hit the same floor: set requires pending_r low.
        pending_s = (pending_r & ~clr_s) | set_s;
        busy_s    = (state_s != ST_IDLE);
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_r <= '0;
            ptr_r     <= '0;
            cnt_r     <= '0;
            car_en_r  <= 1'b0;
            origin_r  <= '0;
            cdest_r   <= '0;
            ack_r     <= '0;
            reject_r  <= '0;
            busy_r    <= 1'b0;
            for (int f = 0; f < NFLOORS; f++) dest_r[f] <= '0;
        end else begin
            pending_r <= pending_s;
            ptr_r     <= ptr_s;
            cnt_r     <= cnt_s;
            car_en_r  <= car_en_s;
            origin_r  <= origin_s;
            cdest_r   <= cdest_s;
            ack_r     <= set_s;
            reject_r  <= reject_s;
            busy_r    <= busy_s;
            for (int f = 0; f < NFLOORS; f++) begin
                if (set_s[f]) dest_r[f] <= call_dest[f*FW +: FW];
            end
        end
    end

    assign car_en       = car_en_r;
    assign car_origin   = origin_r;
    assign car_dest     = cdest_r;
    assign call_ack     = ack_r;
    assign call_reject  = reject_r;
    assign call_pending = pending_r;
    assign busy         = busy_r;

endmodule

// File: tb/tb_elevator_dispatcher.sv
// -----------------------------------------------------------------------------
// Testbench for elevator_dispatcher: directed scenarios followed by random
// requester / car / emergency traffic, all checked every cycle against a
// behavioural model of the scheduling rules.
// -----------------------------------------------------------------------------
module tb_elevator_dispatcher;

    localparam int NF = 5;
    localparam int FW = 3;
    localparam int AT = 8;

    logic              clk;
    logic              reset;
    logic [NF-1:0]     call_req;
    logic [NF*FW-1:0]  call_dest;
    logic              emergency_stop;
    logic              car_idle;
    logic              car_en;
    logic [FW-1:0]     car_origin;
    logic [FW-1:0]     car_dest;
    logic [NF-1:0]     call_ack;
    logic [NF-1:0]     call_reject;
    logic [NF-1:0]     call_pending;
    logic              busy;

    elevator_dispatcher #(.NFLOORS(NF), .FW(FW), .ACCEPT_TIMEOUT(AT)) dut (
        .clk            (clk),
        .reset          (reset),
        .call_req       (call_req),
        .call_dest      (call_dest),
        .emergency_stop (emergency_stop),
        .car_idle       (car_idle),
        .car_en         (car_en),
        .car_origin     (car_origin),
        .car_dest       (car_dest),
        .call_ack       (call_ack),
        .call_reject    (call_reject),
        .call_pending   (call_pending),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // Stimulus variables
    logic [NF-1:0]    req_v;
    logic [NF*FW-1:0] dest_v;
    logic             estop_v;
    logic             idle_v;

    // Behavioural model
    localparam int M_READY = 0, M_SERVE = 1, M_TRAVEL = 2, M_HALT = 3;
    bit [NF-1:0] m_pending, m_ack, m_rej;
    int          m_dest [NF];
    int          m_ptr, m_mode, m_org, m_dst, m_start, cyc;
    bit          m_en;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        m_pending = '0; m_ack = '0; m_rej = '0;
        for (int f = 0; f < NF; f++) m_dest[f] = 0;
        m_ptr = 0; m_mode = M_READY; m_org = 0; m_dst = 0; m_start = 0; m_en = 0;
    endtask

    task automatic model_step();
        bit [NF-1:0] pend_next;
        bit found;
        int fl, d;
        cyc++;
        m_ack = '0; m_rej = '0;
        pend_next = m_pending;
        found = 0; fl = 0;
        for (int f = 0; f < NF; f++) begin
            if (req_v[f] && !m_pending[f]) begin
                d = int'(dest_v[f*FW +: FW]);
                if (d == f || d >= NF) m_rej[f] = 1;
                else begin pend_next[f] = 1; m_dest[f] = d; m_ack[f] = 1; end
            end
        end
        if (estop_v) begin
            m_mode = M_HALT; m_en = 0;
        end else if (m_mode == M_READY) begin
            for (int k = 0; k < NF; k++)
                if (!found && m_pending[(m_ptr + k) % NF]) begin found = 1; fl = (m_ptr + k) % NF; end
            if (found && idle_v) begin
                m_en = 1; m_org = fl; m_dst = m_dest[fl]; m_start = cyc; m_mode = M_SERVE;
            end
        end else if (m_mode == M_SERVE) begin
            if (!idle_v) begin
                m_en = 0; pend_next[m_org] = 0; m_ptr = (m_org + 1) % NF; m_mode = M_TRAVEL;
            end else if (cyc - m_start == AT) begin
                m_en = 0; m_ptr = (m_org + 1) % NF; m_mode = M_READY;
            end
        end else begin
            if (idle_v) m_mode = M_READY;
        end
        m_pending = pend_next;
    endtask

    task automatic compare_all();
        check_value("car_en",       32'(car_en),       32'(m_en));
        check_value("car_origin",   32'(car_origin),   32'(m_org));
        check_value("car_dest",     32'(car_dest),     32'(m_dst));
        check_value("call_ack",     32'(call_ack),     32'(m_ack));
        check_value("call_reject",  32'(call_reject),  32'(m_rej));
        check_value("call_pending", 32'(call_pending), 32'(m_pending));
        check_value("busy",         32'(busy),         32'(m_mode != M_READY));
    endtask

    // One clock: compare at negedge, release answered requests, drive, step model at posedge.
    task automatic tick();
        compare_all();
        req_v = req_v & ~(m_ack | m_rej);
        call_req = req_v; call_dest = dest_v; emergency_stop = estop_v; car_idle = idle_v;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic rand_inputs();
        int d;
        if ($urandom_range(3, 0) == 0) idle_v = ~idle_v;
        if (estop_v) begin
            if ($urandom_range(5, 0) == 0) estop_v = 1'b0;
        end else if ($urandom_range(59, 0) == 0) estop_v = 1'b1;
        for (int f = 0; f < NF; f++) begin
            if (!req_v[f] && $urandom_range(7, 0) == 0) begin
                if ($urandom_range(7, 0) == 0) d = int'($urandom_range(7, 0));
                else begin
                    d = int'($urandom_range(NF - 1, 0));
                    if (d == f) d = (d + 1) % NF;
                end
                req_v[f] = 1'b1;
                dest_v[f*FW +: FW] = FW'(d);
            end
        end
    endtask

    initial begin
        int order [$];
        int exp_order [4];
        int cnt;
        bit prev_en;
        bit injected;
        clk = 1'b0; reset = 1'b0;
        req_v = '0; dest_v = '0; estop_v = 1'b0; idle_v = 1'b1;
        call_req = '0; call_dest = '0; emergency_stop = 1'b0; car_idle = 1'b1;
        cyc = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_value("rst_car_en",  32'(car_en), 32'd0);
        check_value("rst_busy",    32'(busy), 32'd0);
        check_value("rst_pending", 32'(call_pending), 32'd0);
        check_value("rst_origin",  32'(car_origin), 32'd0);
        check_value("rst_dest",    32'(car_dest), 32'd0);
        check_value("rst_ack",     32'(call_ack), 32'd0);
        check_value("rst_reject",  32'(call_reject), 32'd0);
        reset = 1'b1;

        // Round-robin: floors 0, 3, 4 together; floor 1 arrives while 3 is served.
        req_v = 5'b11001;
        dest_v[0*FW +: FW] = 3'd2; dest_v[3*FW +: FW] = 3'd1; dest_v[4*FW +: FW] = 3'd0;
        prev_en = 1'b0; injected = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (car_en && !prev_en) begin
                order.push_back(int'(car_origin));
                if (car_origin == 3'd3 && !injected) begin
                    req_v[1] = 1'b1; dest_v[1*FW +: FW] = 3'd2; injected = 1'b1;
                end
            end
            prev_en = car_en;
            idle_v  = car_en ? 1'b0 : 1'b1;
            tick();
        end
        exp_order = '{0, 3, 4, 1};
        check_value("rr_count", 32'(order.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            check_value("rr_order", (i < order.size()) ? 32'(order[i]) : 32'hFF, 32'(exp_order[i]));

        // Single call floor 2 -> 4.
        idle_v = 1'b1;
        req_v[2] = 1'b1; dest_v[2*FW +: FW] = 3'd4;
        tick();
        check_value("single_ack", 32'(call_ack), 32'b00100);
        tick();
        check_value("single_en",     32'(car_en), 32'd1);
        check_value("single_origin", 32'(car_origin), 32'd2);
        check_value("single_dest",   32'(car_dest), 32'd4);
        tick(); tick();
        idle_v = 1'b0;
        tick();
        check_value("single_accept_en", 32'(car_en), 32'd0);
        check_value("single_cleared",   32'(call_pending), 32'd0);
        idle_v = 1'b1;
        tick();
        check_value("single_busy_done", 32'(busy), 32'd0);

        // Invalid calls: dest equal to origin and dest out of range.
        req_v[1] = 1'b1; dest_v[1*FW +: FW] = 3'd1;
        req_v[0] = 1'b1; dest_v[0*FW +: FW] = 3'd6;
        tick();
        check_value("inv_reject",  32'(call_reject), 32'b00011);
        check_value("inv_pending", 32'(call_pending), 32'd0);
        tick();
        check_value("inv_no_en", 32'(car_en), 32'd0);

        // Timeout: car never leaves idle.
        req_v[3] = 1'b1; dest_v[3*FW +: FW] = 3'd0;
        tick(); tick();
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (!car_en) break;
            cnt++;
            tick();
        end
        check_value("tmo_en_cycles", 32'(cnt), 32'(AT));
        check_value("tmo_kept", 32'(call_pending), 32'b01000);

        // Emergency during dispatch, call accepted while halted, resume in RR order.
        tick();
        check_value("emg_reissue", 32'(car_en), 32'd1);
        estop_v = 1'b1;
        tick();
        check_value("emg_en_low",  32'(car_en), 32'd0);
        check_value("emg_kept",    32'(call_pending), 32'b01000);
        check_value("emg_busy",    32'(busy), 32'd1);
        req_v[0] = 1'b1; dest_v[0*FW +: FW] = 3'd2;
        tick();
        check_value("emg_halt_ack", 32'(call_ack), 32'b00001);
        estop_v = 1'b0;
        tick();
        check_value("emg_release_busy", 32'(busy), 32'd0);
        tick();
        check_value("emg_resume_en",     32'(car_en), 32'd1);
        check_value("emg_resume_origin", 32'(car_origin), 32'd0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            tick();
        end

        // Asynchronous reset in the middle of a dispatch.
        estop_v = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (car_en) break;
            rand_inputs();
            estop_v = 1'b0;
            tick();
        end
        check_value("midrst_reached", 32'(car_en), 32'd1);
        #2 reset = 1'b0;
        #1;
        check_value("midrst_car_en",  32'(car_en), 32'd0);
        check_value("midrst_busy",    32'(busy), 32'd0);
        check_value("midrst_pending", 32'(call_pending), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 600; i++) begin
            rand_inputs();
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
